// File: rtl/multicycle_controller_pkg.sv
`default_nettype none
// ============================================================================
// cpu_ctrl_pkg : opcodes, state enum, mux encodings and ALU function codes
//                shared by the multicycle stack-CPU controller.
// Revision     : 1.0
// ============================================================================
package cpu_ctrl_pkg;

    localparam logic [4:0] c_op_push       = 5'b00000;
    localparam logic [4:0] c_op_pop        = 5'b00001;
    localparam logic [4:0] c_op_br         = 5'b10000;
    localparam logic [4:0] c_op_call       = 5'b10001;
    localparam logic [4:0] c_op_ret        = 5'b10010;
    localparam logic [1:0] c_op_alu_prefix = 2'b01;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_MEM    = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [1:0] c_addr_pc    = 2'd0;
    localparam logic [1:0] c_addr_sp    = 2'd1;
    localparam logic [1:0] c_addr_sp_m1 = 2'd2;

    localparam logic [1:0] c_pc_inc = 2'd0;
    localparam logic [1:0] c_pc_rel = 2'd1;
    localparam logic [1:0] c_pc_mdr = 2'd2;

    localparam logic [2:0] c_alu_pass = 3'b000;
    localparam logic [2:0] c_alu_inc  = 3'b001;
    localparam logic [2:0] c_alu_add  = 3'b010;
    localparam logic [2:0] c_alu_neg  = 3'b011;
    localparam logic [2:0] c_alu_or   = 3'b100;
    localparam logic [2:0] c_alu_not  = 3'b101;
    localparam logic [2:0] c_alu_dec  = 3'b110;

    // Exactly one bit is set for any opcode.
    typedef struct packed {
        logic push;
        logic pop;
        logic alu;
        logic br;
        logic call;
        logic ret;
        logic halt;
        logic undef;
    } op_class_t;

endpackage
`default_nettype wire

// File: rtl/multicycle_controller_decoder.sv
`default_nettype none
// ============================================================================
// opcode_class_decoder : combinational IR[15:11] -> one-hot instruction class.
// Revision             : 1.0
// ============================================================================
module opcode_class_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter logic [4:0] HALT_OPCODE = 5'b11111
) (
    input  logic [4:0] opcode,
    output op_class_t  op_class
);

    // HALT is matched first so a relocated HALT_OPCODE still yields one-hot.
    always_comb begin
        op_class = '0;
        if (opcode == HALT_OPCODE) begin
            op_class.halt = 1'b1;
        end else if (opcode[4:3] == c_op_alu_prefix) begin
            op_class.alu = 1'b1;
        end else begin
            case (opcode)
                c_op_push: op_class.push  = 1'b1;
                c_op_pop:  op_class.pop   = 1'b1;
                c_op_br:   op_class.br    = 1'b1;
                c_op_call: op_class.call  = 1'b1;
                c_op_ret:  op_class.ret   = 1'b1;
                default:   op_class.undef = 1'b1;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// multicycle_controller : FETCH/DECODE/MEM/WB sequencer for the 16-bit stack
//                         CPU. ILLEGAL_TRAP_EN adds TRAP state and illegal port.
// Revision              : 1.0
// ============================================================================
module multicycle_controller
    import cpu_ctrl_pkg::*;
#(
    parameter logic [4:0]  HALT_OPCODE = 5'b11111,
    parameter int unsigned WAIT_MAX    = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] ir,
    input  logic        mem_ready,
    input  logic        cond_true,
    output logic        ld_ir,
    output logic        ld_mdr,
    output logic        ld_pc,
    output logic        ld_sp,
    output logic        ld_reg,
    output logic        ld_flg,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  addr_sel,
    output logic        din_sel,
    output logic        sp_dec,
    output logic [1:0]  pc_sel,
    output logic        reg_src,
    output logic [2:0]  func_sel,
    output logic [2:0]  reg_sel,
    output logic [3:0]  cond_sel,
    output logic        halted,
`ifdef ILLEGAL_TRAP_EN
    output logic        illegal,
`endif
    output logic        mem_timeout
);

    localparam logic [3:0] c_wait_max = WAIT_MAX[3:0];
    localparam logic [3:0] c_wait_pre = c_wait_max - 4'd1;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [3:0]  wait_q, wait_d;
    op_class_t   w_cls;
    logic        w_unused;

    opcode_class_decoder #(
        .HALT_OPCODE (HALT_OPCODE)
    ) u_decoder (
        .opcode   (ir_q[15:11]),
        .op_class (w_cls)
    );

    // IR[6:3] only feeds the datapath offset adder.
    assign w_unused = ^{ir_q[6:3], w_cls.undef};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_FETCH;
            ir_q    <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        wait_d      = 4'd0;
        ld_ir       = 1'b0;
        ld_mdr      = 1'b0;
        ld_pc       = 1'b0;
        ld_sp       = 1'b0;
        ld_reg      = 1'b0;
        ld_flg      = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        addr_sel    = c_addr_pc;
        din_sel     = 1'b0;
        sp_dec      = 1'b0;
        pc_sel      = c_pc_inc;
        reg_src     = 1'b0;
        func_sel    = c_alu_pass;
        reg_sel     = 3'd0;
        cond_sel    = 4'd0;
        halted      = 1'b0;
        mem_timeout = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        illegal     = 1'b0;
`endif

        // Outputs stay quiet for the whole reset cycle, whatever the state.
        if (!reset) begin
            reg_sel  = ir_q[2:0];
            cond_sel = ir_q[10:7];
            func_sel = w_cls.alu ? ir_q[13:11] : c_alu_pass;

            unique case (state_q)
                ST_FETCH: begin
                    mem_req  = 1'b1;
                    addr_sel = c_addr_pc;
                    if (mem_ready) begin
                        ld_ir   = 1'b1;
                        ir_d    = ir;
                        state_d = ST_DECODE;
                    end else begin
                        mem_timeout = (wait_q == c_wait_pre);
                        wait_d      = (wait_q == c_wait_max) ? wait_q : wait_q + 4'd1;
                    end
                end
                ST_DECODE: begin
                    if (w_cls.halt) begin
                        state_d = ST_HALT;
                    end else if (w_cls.push | w_cls.pop | w_cls.alu | w_cls.call | w_cls.ret) begin
                        state_d = ST_MEM;
`ifdef ILLEGAL_TRAP_EN
                    end else if (w_cls.undef) begin
                        state_d = ST_TRAP;
`endif
                    end else begin
                        state_d = ST_WB;
                    end
                end
                ST_MEM: begin
                    mem_req = 1'b1;
                    if (w_cls.push | w_cls.call) begin
                        mem_we   = 1'b1;
                        addr_sel = c_addr_sp_m1;
                        din_sel  = w_cls.call;
                    end else begin
                        addr_sel = c_addr_sp;
                    end
                    if (mem_ready) begin
                        ld_mdr  = w_cls.pop | w_cls.alu | w_cls.ret;
                        state_d = ST_WB;
                    end else begin
                        mem_timeout = (wait_q == c_wait_pre);
                        wait_d      = (wait_q == c_wait_max) ? wait_q : wait_q + 4'd1;
                    end
                end
                ST_WB: begin
                    ld_pc   = 1'b1;
                    state_d = ST_FETCH;
                    if (w_cls.push) begin
                        ld_sp  = 1'b1;
                        sp_dec = 1'b1;
                    end
                    if (w_cls.pop) begin
                        ld_reg  = 1'b1;
                        reg_src = 1'b1;
                        ld_sp   = 1'b1;
                    end
                    if (w_cls.alu) begin
                        ld_reg = 1'b1;
                        ld_flg = 1'b1;
                    end
                    if (w_cls.br) begin
                        pc_sel = cond_true ? c_pc_rel : c_pc_inc;
                    end
                    if (w_cls.call) begin
                        ld_sp  = 1'b1;
                        sp_dec = 1'b1;
                        pc_sel = c_pc_rel;
                    end
                    if (w_cls.ret) begin
                        ld_sp  = 1'b1;
                        pc_sel = c_pc_mdr;
                    end
                end
                ST_HALT: begin
                    halted = 1'b1;
                end
                ST_TRAP: begin
                    halted = 1'b1;
`ifdef ILLEGAL_TRAP_EN
                    illegal = 1'b1;
`endif
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// tb_multicycle_controller : vector table + instruction-level trace model.
// Revision                 : 1.0
// ============================================================================
module tb_multicycle_controller;

    localparam int WAIT_MAX = 15;
`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef struct packed {
        logic       ld_ir, ld_mdr, ld_pc, ld_sp, ld_reg, ld_flg, mem_req, mem_we;
        logic [1:0] addr_sel;
        logic       din_sel, sp_dec;
        logic [1:0] pc_sel;
        logic       reg_src;
        logic [2:0] func_sel, reg_sel;
        logic [3:0] cond_sel;
        logic       halted, mem_timeout, illegal;
    } outs_t;

    typedef struct {
        logic        rst;
        logic [15:0] ir;
        logic        rdy;
        logic        ct;
        outs_t       exp;
        string       name;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset, mem_ready, cond_true;
    logic [15:0] ir;
    logic        ld_ir, ld_mdr, ld_pc, ld_sp, ld_reg, ld_flg, mem_req, mem_we;
    logic [1:0]  addr_sel, pc_sel;
    logic        din_sel, sp_dec, reg_src, halted, mem_timeout, illegal_w;
    logic [2:0]  func_sel, reg_sel;
    logic [3:0]  cond_sel;
    outs_t       got;

    int          n_checks = 0;
    int          n_fail   = 0;
    vec_t        q[$];
    logic [15:0] prev_ir;

    always #5 clock = ~clock;

    multicycle_controller dut (
        .clock       (clock),
        .reset       (reset),
        .ir          (ir),
        .mem_ready   (mem_ready),
        .cond_true   (cond_true),
        .ld_ir       (ld_ir),
        .ld_mdr      (ld_mdr),
        .ld_pc       (ld_pc),
        .ld_sp       (ld_sp),
        .ld_reg      (ld_reg),
        .ld_flg      (ld_flg),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .addr_sel    (addr_sel),
        .din_sel     (din_sel),
        .sp_dec      (sp_dec),
        .pc_sel      (pc_sel),
        .reg_src     (reg_src),
        .func_sel    (func_sel),
        .reg_sel     (reg_sel),
        .cond_sel    (cond_sel),
        .halted      (halted),
`ifdef ILLEGAL_TRAP_EN
        .illegal     (illegal_w),
`endif
        .mem_timeout (mem_timeout)
    );

`ifndef ILLEGAL_TRAP_EN
    assign illegal_w = 1'b0;
`endif

    assign got = {ld_ir, ld_mdr, ld_pc, ld_sp, ld_reg, ld_flg, mem_req, mem_we,
                  addr_sel, din_sel, sp_dec, pc_sel, reg_src, func_sel, reg_sel,
                  cond_sel, halted, mem_timeout, illegal_w};

    function automatic vec_t mk(input logic r, input logic [15:0] w, input logic rd,
                                input logic c, input outs_t e, input string nm);
        vec_t v;
        v.rst = r; v.ir = w; v.rdy = rd; v.ct = c; v.exp = e; v.name = nm;
        return v;
    endfunction

    // Field selects always follow the most recently latched instruction.
    function automatic outs_t sel_o(input logic [15:0] w);
        outs_t e;
        e          = '0;
        e.reg_sel  = w[2:0];
        e.cond_sel = w[10:7];
        e.func_sel = (w[15:14] == 2'b01) ? w[13:11] : 3'b000;
        return e;
    endfunction

    // Expected cycle trace of one instruction with fw fetch waits and mw memory waits.
    task automatic gen_insn(input logic [15:0] w, input int fw, input int mw,
                            input int hold, input int max_cyc);
        vec_t      lq[$];
        outs_t     e;
        logic [4:0] op;
        bit        is_push, is_pop, is_alu, is_br, is_call, is_ret, is_halt, is_undef, stops;
        logic      ct;
        op       = w[15:11];
        is_push  = (op == 5'b00000);
        is_pop   = (op == 5'b00001);
        is_alu   = (op[4:3] == 2'b01);
        is_br    = (op == 5'b10000);
        is_call  = (op == 5'b10001);
        is_ret   = (op == 5'b10010);
        is_halt  = (op == 5'b11111);
        is_undef = !(is_push || is_pop || is_alu || is_br || is_call || is_ret || is_halt);
        stops    = is_halt || (is_undef && TRAP_EN);
        for (int k = 1; k <= fw; k++) begin
            e = sel_o(prev_ir); e.mem_req = 1'b1; e.mem_timeout = (k == WAIT_MAX);
            lq.push_back(mk(0, 16'($urandom), 0, 1'($urandom), e, "fetch_wait"));
        end
        e = sel_o(prev_ir); e.mem_req = 1'b1; e.ld_ir = 1'b1;
        lq.push_back(mk(0, w, 1, 1'($urandom), e, "fetch"));
        lq.push_back(mk(0, 16'($urandom), 1'($urandom), 1'($urandom), sel_o(w), "decode"));
        if (stops) begin
            for (int h = 0; h < hold; h++) begin
                e = sel_o(w); e.halted = 1'b1; e.illegal = is_undef;
                lq.push_back(mk(0, 16'($urandom), 1'($urandom), 1'($urandom), e, "halt"));
            end
            lq.push_back(mk(1, 16'($urandom), 1'($urandom), 1'($urandom), '0, "reset"));
        end else begin
            if (is_push || is_pop || is_alu || is_call || is_ret) begin
                for (int k = 1; k <= mw + 1; k++) begin
                    e = sel_o(w); e.mem_req = 1'b1;
                    if (is_push || is_call) begin
                        e.mem_we = 1'b1; e.addr_sel = 2'd2; e.din_sel = is_call;
                    end else begin
                        e.addr_sel = 2'd1;
                    end
                    if (k > mw) e.ld_mdr = is_pop || is_alu || is_ret;
                    else        e.mem_timeout = (k == WAIT_MAX);
                    lq.push_back(mk(0, 16'($urandom), (k > mw), 1'($urandom), e,
                                    (k > mw) ? "mem" : "mem_wait"));
                end
            end
            ct = 1'($urandom);
            e = sel_o(w); e.ld_pc = 1'b1;
            if (is_push) begin e.ld_sp = 1; e.sp_dec = 1; end
            if (is_pop)  begin e.ld_reg = 1; e.reg_src = 1; e.ld_sp = 1; end
            if (is_alu)  begin e.ld_reg = 1; e.ld_flg = 1; end
            if (is_br)   e.pc_sel = ct ? 2'd1 : 2'd0;
            if (is_call) begin e.ld_sp = 1; e.sp_dec = 1; e.pc_sel = 2'd1; end
            if (is_ret)  begin e.ld_sp = 1; e.pc_sel = 2'd2; end
            lq.push_back(mk(0, 16'($urandom), 1'($urandom), ct, e, "wb"));
        end
        for (int i = 0; i < lq.size() && i < max_cyc; i++) q.push_back(lq[i]);
        prev_ir = stops ? 16'h0000 : w;
        if (lq.size() > max_cyc) begin
            q.push_back(mk(1, 16'($urandom), 1'($urandom), 1'($urandom), '0, "reset_abort"));
            prev_ir = 16'h0000;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got=timeout required=finish");
        $fatal(1);
    end

    initial begin
        outs_t e;
        logic [15:0] w;
        int fw, mw;

        // Hand-filled vectors: reset, then a taken BR +5 with zero-wait memory.
        e = '0;                                   q.push_back(mk(1, 16'h0000, 1, 0, e, "reset_state"));
        e = '0; e.mem_req = 1; e.ld_ir = 1;       q.push_back(mk(0, 16'h8005, 1, 0, e, "br_fetch"));
        e = '0; e.reg_sel = 3'd5;                 q.push_back(mk(0, 16'hFFFF, 1, 0, e, "br_decode"));
        e.ld_pc = 1; e.pc_sel = 2'd1;             q.push_back(mk(0, 16'hFFFF, 1, 1, e, "br_wb"));
        prev_ir = 16'h8005;

        gen_insn(16'h0003, 0, 3, 3, 1000);        // PUSH R3, 3 memory waits
        gen_insn(16'h5002, 1, 0, 3, 1000);        // ALU add R2
        gen_insn(16'h8805, 0, 0, 3, 1000);        // CALL
        gen_insn(16'h9000, 0, 2, 3, 1000);        // RET
        gen_insn(16'h0801, 2, 1, 3, 1000);        // POP R1
        gen_insn(16'hB800, 0, 0, 3, 1000);        // undefined opcode 10111
        gen_insn(16'h8385, 17, 0, 3, 1000);       // fetch stall past WAIT_MAX
        gen_insn(16'h0805, 0, 16, 3, 1000);       // memory stall past WAIT_MAX
        for (int n = 0; n < 60; n++) begin
            w  = 16'($urandom);
            fw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(3, 9)) : int'($urandom_range(0, 2));
            mw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(3, 9)) : int'($urandom_range(0, 2));
            gen_insn(w, fw, mw, 3, 1000);
        end
        gen_insn(16'h1234, 20, 0, 3, 9);          // reset on 10th cycle of a fetch stall
        gen_insn(16'h0003, 0, 5, 3, 4);           // reset in the middle of MEM
        gen_insn(16'hF805, 0, 0, 20, 1000);       // HALT held for 20 cycles
        gen_insn(16'h8005, 0, 0, 3, 1000);

        for (int i = 0; i < q.size(); i++) begin
            @(negedge clock);
            reset     = q[i].rst;
            ir        = q[i].ir;
            mem_ready = q[i].rdy;
            cond_true = q[i].ct;
            #1;
            n_checks++;
            if (got !== q[i].exp) begin
                n_fail++;
                $display("FAIL %s vec=%0d got=%h required=%h", q[i].name, i, got, q[i].exp);
            end
        end

        @(negedge clock);
        reset     = 1'b0;
        ir        = 16'h0000;
        mem_ready = 1'b0;
        cond_true = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL post_fetch mem_req got=%b required=1", mem_req);
        end
        n_checks++;
        if (ld_ir !== 1'b0) begin
            n_fail++;
            $display("FAIL post_fetch ld_ir got=%b required=0", ld_ir);
        end
        n_checks++;
        if (addr_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL post_fetch addr_sel got=%0d required=0", addr_sel);
        end
        n_checks++;
        if (halted !== 1'b0) begin
            n_fail++;
            $display("FAIL post_fetch halted got=%b required=0", halted);
        end
        n_checks++;
        if (mem_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL post_fetch mem_timeout got=%b required=0", mem_timeout);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
